// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: grants NUM_CH channels onto one req/addr_ok/data_ok memory port and routes in-order responses back through an ID FIFO
module sram_like_arbiter #(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int OUTSTANDING = 4,
  parameter int PRIO_MODE   = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            ch_req,
  input  logic [NUM_CH-1:0]            ch_wr,
  input  logic [2*NUM_CH-1:0]          ch_size,
  input  logic [ADDR_W*NUM_CH-1:0]     ch_addr,
  input  logic [DATA_W*NUM_CH-1:0]     ch_wdata,
  output logic [NUM_CH-1:0]            ch_addr_ok,
  output logic [NUM_CH-1:0]            ch_data_ok,
  output logic [DATA_W-1:0]            ch_rdata,
  output logic                         m_req,
  output logic                         m_wr,
  output logic [1:0]                   m_size,
  output logic [ADDR_W-1:0]            m_addr,
  output logic [DATA_W-1:0]            m_wdata,
  input  logic                         m_addr_ok,
  input  logic                         m_data_ok,
  input  logic [DATA_W-1:0]            m_rdata,
  output logic [$clog2(OUTSTANDING):0] pending_cnt,
  output logic                         err
);
  localparam int CW = $clog2(NUM_CH);
  localparam int PW = $clog2(OUTSTANDING);
  logic [CW-1:0] rr_q, rr_d, lock_id_q, lock_id_d, sel, cand, id;
  logic          lock_q, lock_d, err_q, err_d, push, pop, empty, full;
  logic [PW:0]   wr_q, wr_d, rd_q, rd_d, cnt;
  logic [CW-1:0] fifo_q [OUTSTANDING];
  always_comb begin
    sel  = '0;
    cand = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (PRIO_MODE == 0 && ch_req[k]) sel = CW'(k);
      cand = CW'((int'(rr_q) + NUM_CH - 1 - k) % NUM_CH);
      if (PRIO_MODE != 0 && ch_req[cand]) sel = cand;
    end
    id          = lock_q ? lock_id_q : sel;
    cnt         = wr_q - rd_q;
    full        = cnt == (PW+1)'(OUTSTANDING);
    empty       = cnt == '0;
    m_req       = !reset && (|ch_req || lock_q) && !full;
    m_wr        = ch_wr[id];
    m_size      = ch_size[2*id +: 2];
    m_addr      = ch_addr[id*ADDR_W +: ADDR_W];
    m_wdata     = ch_wdata[id*DATA_W +: DATA_W];
    push        = m_req && m_addr_ok;
    pop         = !reset && m_data_ok && !empty;
    ch_addr_ok  = push ? NUM_CH'(1) << id : '0;
    ch_data_ok  = pop ? NUM_CH'(1) << fifo_q[rd_q[PW-1:0]] : '0;
    ch_rdata    = m_rdata;
    pending_cnt = reset ? '0 : cnt;
    err         = err_q && !reset;
    wr_d        = wr_q + (PW+1)'(push);
    rd_d        = rd_q + (PW+1)'(pop);
    lock_d      = !push && (lock_q || m_req);
    lock_id_d   = id;
    rr_d        = (PRIO_MODE != 0 && push) ? (id == CW'(NUM_CH-1) ? '0 : id + 1'b1) : rr_q;
    err_d       = err_q || (m_data_ok && empty);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q      <= '0;
      rd_q      <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      rr_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      rr_q      <= rr_d;
      err_q     <= err_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_q[PW-1:0]] <= id;
  end
endmodule

// File: doc/sram_like_arbiter.md
# sram_like_arbiter

Parametrised request arbiter between NUM_CH CPU memory channels (instruction fetch, data access) and a single sram-like memory port using a req/addr_ok/data_ok handshake. It accepts up to OUTSTANDING address handshakes before the matching responses return, records the owning channel of each in an in-order ID FIFO, and routes each data_ok/rdata back to the owning channel. It sits between the CPU top's pipeline stages and the memory-side bridge, replacing the fixed single-cycle SRAM ports.

## Interface
- NUM_CH, 2, number of requesting channels (2..8); channel 0 = inst, channel 1 = data by convention
- ADDR_W, 32, address width
- DATA_W, 32, data width
- OUTSTANDING, 4, ID FIFO depth (power of 2, ≥2)
- PRIO_MODE, 0, 0 = fixed priority (highest index wins), 1 = round-robin

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ch_req  in  NUM_CH  per-channel request
- ch_wr  in  NUM_CH  per-channel write flag
- ch_size  in  2*NUM_CH  per-channel size (0 = byte, 1 = half, 2 = word), channel i at [2i+1:2i]
- ch_addr  in  ADDR_W*NUM_CH  per-channel address, flattened
- ch_wdata  in  DATA_W*NUM_CH  per-channel write data, flattened
- ch_addr_ok  out  NUM_CH  address handshake completed for channel i
- ch_data_ok  out  NUM_CH  response returned for channel i
- ch_rdata  out  DATA_W  read data, broadcast to all channels
- m_req, m_wr  out  1  memory-side request / write flag
- m_size  out  2  memory-side size
- m_addr  out  ADDR_W  memory-side address
- m_wdata  out  DATA_W  memory-side write data
- m_addr_ok  in  1  memory accepted address
- m_data_ok  in  1  memory returned response
- m_rdata  in  DATA_W  memory read data
- pending_cnt  out  clog2(OUTSTANDING)+1  outstanding request count
- err  out  1  sticky protocol error

## Operation
- Grant: one-hot grant chosen combinationally among asserted ch_req. PRIO_MODE 0 selects the highest index. PRIO_MODE 1 searches upward from rr_ptr, wrapping.
- m_req = (any ch_req or lock_valid) && !fifo_full. m_wr, m_size, m_addr and m_wdata are muxed from the granted channel.
- Lock: if m_req && !m_addr_ok, the grant is registered (lock_valid, lock_id). It holds until the handshake completes, so request fields stay stable. Higher-priority arrivals do not preempt a locked grant.
- Handshake: m_req && m_addr_ok.
  - ch_addr_ok[g] = 1 in the same cycle.
  - g is pushed into the ID FIFO.
  - lock is cleared.
  - In PRIO_MODE 1, rr_ptr <= (g+1) mod NUM_CH.
- Response: m_data_ok with FIFO non-empty.
  - ch_data_ok[head] = 1 and ch_rdata = m_rdata in the same cycle.
  - The head is popped.
- Push and pop in the same cycle: both are performed and pending_cnt is unchanged.
- Full: m_req is held 0 while pending_cnt == OUTSTANDING, even if a pop occurs that cycle. There is no bypass.
- A pop on the full cycle frees a slot, so m_req may re-assert on the following cycle.
- m_data_ok while the FIFO is empty: ignored (no ch_data_ok asserted) and err is set. err clears only on reset.
- FIFO pointers wrap modulo OUTSTANDING. pending_cnt = wr_ptr − rd_ptr in the extended width.
- Channel deasserting ch_req while locked: the lock persists and the request is issued anyway. Deasserting while locked is a channel protocol violation and does not set err.

## Timing
- Request path is combinational, 0 cycles: ch_req → m_req, and m_addr_ok → ch_addr_ok.
- Response path is combinational: m_data_ok → ch_data_ok.
- A response may arrive at the earliest one cycle after its own address handshake.
- m_data_ok in the same cycle as a push into an empty FIFO counts as the empty case: err is set.
- Reset (synchronous, any cycle, including mid-flight) sets:
  - FIFO pointers 0, pending_cnt 0
  - lock_valid 0, rr_ptr 0, err 0
  - No response is ever delivered for a request outstanding before reset; the memory side is reset together.
- Output values while reset is held: m_req 0, ch_addr_ok 0, ch_data_ok 0, pending_cnt 0, err 0.
- ch_rdata mirrors m_rdata at all times. This includes the reset cycle.

## Test plan
- Single read, NUM_CH=2: ch_req=2'b01, addr 0xBFC00000; m_addr_ok=1 the same cycle; m_data_ok next cycle with m_rdata 0x3C1D0001 → ch_addr_ok=01 at cycle 0, ch_data_ok=01 with rdata 0x3C1D0001 at cycle 1, pending_cnt 1→0.
- Fixed priority plus lock: ch_req=11 with m_addr_ok=0 for 3 cycles, then 1 → m_addr shows ch1's address in every cycle. Only ch_addr_ok[1] fires. ch0 is granted the next cycle.
- Round-robin (PRIO_MODE=1, NUM_CH=4): all four ch_req held and m_addr_ok=1 constant → grants in order 0,1,2,3,0.
- Full and ordering: OUTSTANDING=4, push 4 requests (ids 1,0,1,0) with no data_ok → m_req=0 on the 5th cycle, pending_cnt=4. Four data_ok pulses then return ch_data_ok = 10,01,10,01 in order. Include a cycle with simultaneous push and pop; pending_cnt must stay constant.
- Error and reset: m_data_ok with the FIFO empty → no ch_data_ok, err=1 and sticky. Then reset asserted with 2 requests pending → the next cycle has pending_cnt=0, err=0, m_req=0.
